// File: rtl/downscale_ctrl_if.sv
// Purpose: bundles the pixel stream, downscaler link, bin BRAM port and
//          frame control/status signals of the downscale controller.
// Modports:
//   master - the controller side (drives s_ready, ds_*, bram_*, status, hash)
//   slave  - the environment side (drives start/config, pixels, ds BRAM port,
//            bram_rdata)
interface downscale_ctrl_if #(
   parameter int PIX_WIDTH   = 8,
   parameter int ALPHA_SHIFT = 8,
   parameter int ADDR_WIDTH  = 7
);
   logic                   start;
   logic [15:0]            img_w;
   logic [15:0]            img_h;
   logic [ALPHA_SHIFT-1:0] alpha_recp;

   logic                   s_valid;
   logic                   s_ready;
   logic [PIX_WIDTH-1:0]   s_pix;

   logic                   ds_valid;
   logic [PIX_WIDTH-1:0]   ds_pix;
   logic [15:0]            ds_x;
   logic [15:0]            ds_y;
   logic [ALPHA_SHIFT-1:0] ds_alpha;
   logic [ADDR_WIDTH-1:0]  ds_addr;
   logic [PIX_WIDTH-1:0]   ds_wdata;
   logic                   ds_wen;

   logic [ADDR_WIDTH-1:0]  bram_addr;
   logic [PIX_WIDTH-1:0]   bram_wdata;
   logic                   bram_wen;
   logic [PIX_WIDTH-1:0]   bram_rdata;

   logic                   busy;
   logic                   done;
   logic [63:0]            hash;
   logic                   hash_valid;

   modport master (
      input  start, img_w, img_h, alpha_recp,
      input  s_valid, s_pix,
      output s_ready,
      output ds_valid, ds_pix, ds_x, ds_y, ds_alpha,
      input  ds_addr, ds_wdata, ds_wen,
      output bram_addr, bram_wdata, bram_wen,
      input  bram_rdata,
      output busy, done, hash, hash_valid
   );

   modport slave (
      output start, img_w, img_h, alpha_recp,
      output s_valid, s_pix,
      input  s_ready,
      input  ds_valid, ds_pix, ds_x, ds_y, ds_alpha,
      output ds_addr, ds_wdata, ds_wen,
      input  bram_addr, bram_wdata, bram_wen,
      output bram_rdata,
      input  busy, done, hash, hash_valid
   );
endinterface

// File: rtl/downscale_ctrl.sv
// Purpose: frame sequencer for the 9x8 downscaler. Owns the bin BRAM: clears
//          it, lends it to the downscaler while pixels stream and its pipeline
//          drains, then reads the bins back to build the 64-bit dHash.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - downscale_ctrl_if.master: start/img_w/img_h/alpha_recp config,
//               s_* pixel stream, ds_* downscaler link and its BRAM port,
//               bram_* muxed BRAM port, busy/done/hash/hash_valid status.
// Build option: define DOWNSCALE_DHASH_EN to include the READ phase and the
//               hash computation; otherwise DRAIN goes straight to DONE and
//               the hash stays 0.
//
// state    | meaning
// S_IDLE   | waiting for start; hash/hash_valid from last frame held
// S_CLEAR  | controller writes 0 to every bin, one address per cycle
// S_STREAM | pixels accepted and forwarded; BRAM owned by downscaler
// S_DRAIN  | downscaler pipeline flushes; BRAM still owned by downscaler
// S_READ   | bins read back row-major, adjacent bins compared into hash
// S_DONE   | one-cycle done pulse, hash_valid raised
module downscale_ctrl #(
   parameter int PIX_WIDTH   = 8,
   parameter int TARGET_X    = 9,
   parameter int TARGET_Y    = 8,
   parameter int ALPHA_SHIFT = 8,
   parameter int ADDR_WIDTH  = 7,
   parameter int DS_LATENCY  = 4
) (
   input logic               clk,
   input logic               rst,
   downscale_ctrl_if.master  bus
);

   localparam int NBINS = TARGET_X * TARGET_Y;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NBINS - 1);
   localparam int DW = (DS_LATENCY > 1) ? $clog2(DS_LATENCY) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DS_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_READ, S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_next;

   logic [15:0]            r_img_w;
   logic [15:0]            r_img_h;
   logic [ALPHA_SHIFT-1:0] r_alpha;
   logic [15:0]            r_x;
   logic [15:0]            r_y;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [DW-1:0]          r_drain_cnt;
   logic                   r_ds_valid;
   logic [PIX_WIDTH-1:0]   r_ds_pix;
   logic [15:0]            r_ds_x;
   logic [15:0]            r_ds_y;
   logic [63:0]            r_hash;
   logic                   r_hash_valid;

   logic w_start_ok;
   logic w_hs;
   logic w_x_last;
   logic w_y_last;
   logic w_addr_last;

`ifdef DOWNSCALE_DHASH_EN
   localparam logic [3:0] COL_LAST = 4'(TARGET_X - 1);
   logic                 r_issue_done;
   logic                 r_din_vld;
   logic                 r_din_last;
   logic [PIX_WIDTH-1:0] r_prev;
   logic [3:0]           r_col;
   logic [5:0]           r_bit;
`else
   logic w_unused_rdata;
   assign w_unused_rdata = ^bus.bram_rdata;
`endif

   assign w_start_ok  = (r_state == S_IDLE) && bus.start;
   assign w_hs        = (r_state == S_STREAM) && bus.s_valid;
   assign w_x_last    = (r_x == r_img_w - 16'd1);
   assign w_y_last    = (r_y == r_img_h - 16'd1);
   assign w_addr_last = (r_addr == LAST_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.img_w == 16'd0 || bus.img_h == 16'd0) w_next = S_DONE;
               else                                          w_next = S_CLEAR;
            end
         end
         S_CLEAR:  if (w_addr_last) w_next = S_STREAM;
         S_STREAM: if (w_hs && w_x_last && w_y_last) w_next = S_DRAIN;
         S_DRAIN: begin
            if (r_drain_cnt == '0) begin
`ifdef DOWNSCALE_DHASH_EN
               w_next = S_READ;
`else
               w_next = S_DONE;
`endif
            end
         end
         S_READ: begin
`ifdef DOWNSCALE_DHASH_EN
            if (r_din_last) w_next = S_DONE;
`else
            w_next = S_IDLE;
`endif
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // BRAM ownership: controller in CLEAR/READ, downscaler in STREAM/DRAIN.
   always_comb begin
      bus.bram_addr  = '0;
      bus.bram_wdata = '0;
      bus.bram_wen   = 1'b0;
      case (r_state)
         S_CLEAR: begin
            bus.bram_addr = r_addr;
            bus.bram_wen  = 1'b1;
         end
         S_STREAM, S_DRAIN: begin
            bus.bram_addr  = bus.ds_addr;
            bus.bram_wdata = bus.ds_wdata;
            bus.bram_wen   = bus.ds_wen;
         end
         S_READ:  bus.bram_addr = r_addr;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_img_w      <= '0;
         r_img_h      <= '0;
         r_alpha      <= '0;
         r_x          <= '0;
         r_y          <= '0;
         r_addr       <= '0;
         r_drain_cnt  <= '0;
         r_ds_valid   <= 1'b0;
         r_ds_pix     <= '0;
         r_ds_x       <= '0;
         r_ds_y       <= '0;
         r_hash       <= '0;
         r_hash_valid <= 1'b0;
`ifdef DOWNSCALE_DHASH_EN
         r_issue_done <= 1'b0;
         r_din_vld    <= 1'b0;
         r_din_last   <= 1'b0;
         r_prev       <= '0;
         r_col        <= '0;
         r_bit        <= '0;
`endif
      end else begin
         r_ds_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_img_w      <= bus.img_w;
                  r_img_h      <= bus.img_h;
                  r_alpha      <= bus.alpha_recp;
                  r_x          <= '0;
                  r_y          <= '0;
                  r_addr       <= '0;
                  r_hash       <= '0;
                  r_hash_valid <= 1'b0;
`ifdef DOWNSCALE_DHASH_EN
                  r_issue_done <= 1'b0;
                  r_din_vld    <= 1'b0;
                  r_din_last   <= 1'b0;
                  r_col        <= '0;
                  r_bit        <= '0;
`endif
               end
            end
            S_CLEAR: begin
               // rewind so READ starts from bin 0
               if (w_addr_last) r_addr <= '0;
               else             r_addr <= r_addr + 1'b1;
            end
            S_STREAM: begin
               if (w_hs) begin
                  r_ds_valid <= 1'b1;
                  r_ds_pix   <= bus.s_pix;
                  r_ds_x     <= r_x;
                  r_ds_y     <= r_y;
                  if (w_x_last) begin
                     r_x <= '0;
                     r_y <= r_y + 16'd1;
                  end else begin
                     r_x <= r_x + 16'd1;
                  end
                  if (w_x_last && w_y_last) r_drain_cnt <= DRAIN_LOAD;
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - 1'b1;
            end
`ifdef DOWNSCALE_DHASH_EN
            S_READ: begin
               // address stops at the last bin; one extra cycle catches its data
               if (!r_issue_done) begin
                  if (w_addr_last) r_issue_done <= 1'b1;
                  else             r_addr <= r_addr + 1'b1;
               end
               r_din_vld  <= !r_issue_done;
               r_din_last <= !r_issue_done && w_addr_last;
               if (r_din_vld) begin
                  r_prev <= bus.bram_rdata;
                  // column 0 only primes r_prev; columns 1..8 each yield a bit
                  if (r_col != 4'd0) begin
                     r_hash[r_bit] <= (r_prev > bus.bram_rdata);
                     r_bit         <= r_bit + 6'd1;
                  end
                  r_col <= (r_col == COL_LAST) ? 4'd0 : r_col + 4'd1;
               end
            end
`endif
            default: ;
         endcase
         if (w_next == S_DONE && r_state != S_DONE) r_hash_valid <= 1'b1;
      end
   end

   assign bus.s_ready    = (r_state == S_STREAM);
   assign bus.ds_valid   = r_ds_valid;
   assign bus.ds_pix     = r_ds_pix;
   assign bus.ds_x       = r_ds_x;
   assign bus.ds_y       = r_ds_y;
   assign bus.ds_alpha   = r_alpha;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.done       = (r_state == S_DONE);
   assign bus.hash       = r_hash;
   assign bus.hash_valid = r_hash_valid;

endmodule

// File: tb/tb_downscale_ctrl.sv
module tb_downscale_ctrl;
   localparam int DSL = 4;
`ifdef DOWNSCALE_DHASH_EN
   localparam int EXP_LAT = 1 + DSL + 73;
`else
   localparam int EXP_LAT = 1 + DSL;
`endif
   localparam int PAT_DEC = 0, PAT_INC = 1, PAT_ALT = 2, PAT_MIX = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   downscale_ctrl_if #(.PIX_WIDTH(8), .ALPHA_SHIFT(8), .ADDR_WIDTH(7)) bus ();

   downscale_ctrl #(
      .PIX_WIDTH(8), .TARGET_X(9), .TARGET_Y(8), .ALPHA_SHIFT(8),
      .ADDR_WIDTH(7), .DS_LATENCY(DSL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem [0:127];
   always @(posedge clk) begin
      if (bus.bram_wen) mem[bus.bram_addr] <= bus.bram_wdata;
      bus.bram_rdata <= mem[bus.bram_addr];
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [7:0]  pix;
      logic [15:0] x;
      logic [15:0] y;
   } sb_t;
   sb_t sb_q[$];
   logic [7:0] cur_alpha;
   int out_cnt, clr_wr, clr_bad, ds_wr, done_cnt;

   // scoreboard: pop one expected pixel per ds_valid strobe
   always @(negedge clk) begin
      if (!rst && bus.ds_valid) begin
         out_cnt++;
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL ds_valid_unexpected: got x=%0d y=%0d with empty queue", bus.ds_x, bus.ds_y);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("ds_pix", 64'(bus.ds_pix), 64'(e.pix));
            chk("ds_x", 64'(bus.ds_x), 64'(e.x));
            chk("ds_y", 64'(bus.ds_y), 64'(e.y));
            chk("ds_alpha", 64'(bus.ds_alpha), 64'(cur_alpha));
         end
      end
   end

   // BRAM write monitor: controller writes (ds_wen low) must be the clear sweep
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.bram_wen && !bus.ds_wen) begin
            if (bus.bram_addr != 7'(clr_wr) || bus.bram_wdata != 8'd0) clr_bad++;
            clr_wr++;
         end
         if (bus.bram_wen && bus.ds_wen) ds_wr++;
         if (bus.done) done_cnt++;
      end
   end

   function automatic logic [7:0] pat_val(input int pat, input int k);
      int c;
      c = k % 9;
      case (pat)
         PAT_DEC: return 8'(90 - 10 * c);
         PAT_INC: return 8'(10 + 10 * c);
         PAT_ALT: return (c % 2 == 0) ? 8'd200 : 8'd10;
         default: return 8'((k * 37 + 11) % 256);
      endcase
   endfunction

   function automatic logic [63:0] model_hash(input int pat);
      logic [63:0] h;
      h = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            h[r*8+c] = pat_val(pat, r*9+c) > pat_val(pat, r*9+c+1);
      return h;
   endfunction

   task automatic start_frame(input int w, input int h, input logic [7:0] alpha);
      step();
      clr_wr = 0; clr_bad = 0; ds_wr = 0; done_cnt = 0; out_cnt = 0;
      cur_alpha      = alpha;
      bus.img_w      = 16'(w);
      bus.img_h      = 16'(h);
      bus.alpha_recp = alpha;
      bus.start      = 1'b1;
      step();
      bus.start = 1'b0;
      if (w == 0 || h == 0) begin
         chk("zero_done", 64'(bus.done), 64'd1);
         chk("zero_hash", bus.hash, 64'd0);
         chk("zero_s_ready", 64'(bus.s_ready), 64'd0);
         chk("zero_hash_valid", 64'(bus.hash_valid), 64'd1);
         chk("zero_done_cnt", 64'(done_cnt), 64'd1);
      end else begin
         chk("busy_after_start", 64'(bus.busy), 64'd1);
         chk("hv_cleared", 64'(bus.hash_valid), 64'd0);
         chk("hash_cleared", bus.hash, 64'd0);
      end
   endtask

   task automatic stream(input int w, input int h, input int pat, input int n, input bit restart);
      int guard, pushed, wr;
      logic [15:0] ex, ey;
      logic v;
      logic [7:0] pix;
      sb_t e;
      guard = 0;
      while (!bus.s_ready && guard < 300) begin
         if (restart && guard == 10) begin
            bus.img_w = 16'd3;
            bus.start = 1'b1;
         end else begin
            bus.img_w = 16'(w);
            bus.start = 1'b0;
         end
         step();
         guard++;
      end
      bus.start = 1'b0;
      bus.img_w = 16'(w);
      chk("reach_stream", 64'(bus.s_ready), 64'd1);
      chk("clear_writes", 64'(clr_wr), 64'd72);
      chk("clear_bad", 64'(clr_bad), 64'd0);
      ex = '0; ey = '0; pushed = 0; wr = 0; guard = 0;
      while (pushed < n && guard < 8 * n + 50) begin
         if (!bus.s_ready) begin
            chk("s_ready_held", 64'(bus.s_ready), 64'd1);
            break;
         end
         v   = ($urandom_range(0, 3) != 0);
         pix = 8'($urandom_range(0, 255));
         bus.s_valid = v;
         bus.s_pix   = pix;
         if (v) begin
            e.pix = pix; e.x = ex; e.y = ey;
            sb_q.push_back(e);
            if (ex == 16'(w - 1)) begin
               ex = '0;
               ey = ey + 16'd1;
            end else begin
               ex = ex + 16'd1;
            end
            pushed++;
         end
         if (wr < 72) begin
            bus.ds_wen   = 1'b1;
            bus.ds_addr  = 7'(wr);
            bus.ds_wdata = pat_val(pat, wr);
            wr++;
         end else begin
            bus.ds_wen = 1'b0;
         end
         step();
         guard++;
      end
      bus.s_valid = 1'b0;
      bus.ds_wen  = 1'b0;
      chk("pixels_pushed", 64'(pushed), 64'(n));
   endtask

   task automatic finish_frame(input int w, input int h, input logic [63:0] exp_hash);
      int lat;
      // pixels offered after the last one must not be accepted
      bus.s_valid = 1'b1;
      bus.s_pix   = 8'h5A;
      lat = 1;
      chk("s_ready_after_last", 64'(bus.s_ready), 64'd0);
      while (!bus.done && lat < 300) begin
         step();
         lat++;
      end
      bus.s_valid = 1'b0;
      chk("done_latency", 64'(lat), 64'(EXP_LAT));
      chk("hash", bus.hash, exp_hash);
      chk("hash_valid_at_done", 64'(bus.hash_valid), 64'd1);
      step();
      chk("done_one_cycle", 64'(bus.done), 64'd0);
      chk("hash_valid_held", 64'(bus.hash_valid), 64'd1);
      chk("hash_held", bus.hash, exp_hash);
      chk("idle_after_done", 64'(bus.busy), 64'd0);
      chk("done_count", 64'(done_cnt), 64'd1);
      chk("pix_out", 64'(out_cnt), 64'(w * h));
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      chk("ds_writes", 64'(ds_wr), 64'd72);
   endtask

   typedef struct {
      int          w;
      int          h;
      logic [7:0]  alpha;
      int          pat;
      bit          use_model;
      logic [63:0] exp_hash;
      bit          restart;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input vec_t v);
      logic [63:0] exp;
      exp = v.use_model ? model_hash(v.pat) : v.exp_hash;
`ifndef DOWNSCALE_DHASH_EN
      exp = 64'd0;
`endif
      start_frame(v.w, v.h, v.alpha);
      if (v.w == 0 || v.h == 0) begin
         step();
         chk("zero_idle", 64'(bus.busy), 64'd0);
         chk("zero_done_low", 64'(bus.done), 64'd0);
      end else begin
         stream(v.w, v.h, v.pat, v.w * v.h, v.restart);
         finish_frame(v.w, v.h, exp);
      end
   endtask

   initial begin
      vecs[0] = '{18, 16, 8'd128, PAT_MIX, 1'b1, 64'd0, 1'b0};
      vecs[1] = '{9,  8,  8'd64,  PAT_DEC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[2] = '{0,  8,  8'd17,  PAT_DEC, 1'b0, 64'd0, 1'b0};
      vecs[3] = '{9,  8,  8'd200, PAT_INC, 1'b0, 64'd0, 1'b0};
      vecs[4] = '{9,  8,  8'd33,  PAT_ALT, 1'b0, 64'h5555_5555_5555_5555, 1'b0};
      vecs[5] = '{5,  0,  8'd9,   PAT_ALT, 1'b0, 64'd0, 1'b0};

      for (int i = 0; i < 128; i++) mem[i] = 8'hEE;
      bus.start = 1'b0; bus.img_w = '0; bus.img_h = '0; bus.alpha_recp = '0;
      bus.s_valid = 1'b0; bus.s_pix = '0;
      bus.ds_addr = '0; bus.ds_wdata = '0; bus.ds_wen = 1'b0;

      step();
      step();
      chk("reset_ctrl", 64'({bus.busy, bus.s_ready, bus.ds_valid, bus.done, bus.hash_valid, bus.bram_wen}), 64'd0);
      chk("reset_hash", bus.hash, 64'd0);
      rst = 1'b0;
      step();

      bus.ds_wen = 1'b1; bus.ds_addr = 7'd5; bus.ds_wdata = 8'hAA;
      #1;
      chk("idle_ds_wen_blocked", 64'(bus.bram_wen), 64'd0);
      step();
      bus.ds_wen = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // reset in the middle of STREAM
      start_frame(9, 8, 8'd77);
      stream(9, 8, PAT_DEC, 50, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", 64'({bus.busy, bus.s_ready, bus.ds_valid, bus.done, bus.hash_valid,
          bus.bram_wen, bus.ds_x, bus.ds_y, bus.ds_pix, bus.ds_alpha, bus.bram_addr}), 64'd0);
      chk("rst_mid_hash", bus.hash, 64'd0);
      sb_q.delete();
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_no_done", 64'(done_cnt), 64'd0);
      chk("rst_idle", 64'(bus.busy), 64'd0);
      run_vec(vecs[1]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running at time %0t", $time);
      $fatal(1, "timeout");
   end
endmodule
